// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column sequencing, frame debounce,
// single-key event detection and a small FWFT event FIFO.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    row,
  output logic [3:0]                    col,
  output logic                          ev_valid,
  output logic [3:0]                    ev_code,
  input  logic                          ev_pop,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic                          key_down
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DEBOUNCE_SCANS) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;

  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STB_MAX    = SW'(DEBOUNCE_SCANS - 1);
  localparam logic [NW-1:0] FULL_CNT   = NW'(FIFO_DEPTH);

  // (col,row) position, indexed col*4+row, to key code
  function automatic logic [3:0] key_code(
    input logic [3:0] idx
  );
    logic [3:0] k;
    case (idx)
      4'd0:    k = 4'h1;
      4'd1:    k = 4'h4;
      4'd2:    k = 4'h7;
      4'd3:    k = 4'hE;
      4'd4:    k = 4'h2;
      4'd5:    k = 4'h5;
      4'd6:    k = 4'h8;
      4'd7:    k = 4'h0;
      4'd8:    k = 4'h3;
      4'd9:    k = 4'h6;
      4'd10:   k = 4'h9;
      4'd11:   k = 4'hF;
      4'd12:   k = 4'hA;
      4'd13:   k = 4'hB;
      4'd14:   k = 4'hC;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  // scan sequencing state
  logic [CW-1:0] dwell;
  logic [1:0]    cidx;
  logic          sample;
  logic          frame_done;

  // debounce state
  logic [15:0]   frame;
  logic [15:0]   prev;
  logic [15:0]   deb;
  logic [SW-1:0] stb;

  logic [15:0]   frame_nx;
  logic [SW-1:0] stb_nx;
  logic          commit;
  logic          single_new;
  logic [3:0]    hit_idx;

  // event handoff into the FIFO, one edge after commit
  logic          push_pend;
  logic [3:0]    push_code;

  // FIFO state
  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [NW-1:0] count;
  logic          full;
  logic          do_pop;
  logic          wr_en;
  logic          drop;

  assign sample     = (dwell == DWELL_LAST);
  assign frame_done = sample && (cidx == 2'd3);

  // one-hot column drive decoded from the column index
  always_comb begin
    col = 4'b0000;
    col[cidx] = 1'b1;
  end

  // dwell counter and column rotation
  always_ff @(posedge clk) begin
    if (!rst) begin
      dwell <= '0;
      cidx  <= 2'd0;
    end else if (sample) begin
      dwell <= '0;
      cidx  <= cidx + 2'd1;
    end else begin
      dwell <= dwell + CW'(1);
    end
  end

  // merge the current column's rows into the frame image
  always_comb begin
    frame_nx = frame;
    frame_nx[{cidx, 2'b00} +: 4] = ~row;
  end

  // stable-frame counter update for a completed frame
  always_comb begin
    stb_nx = '0;
    if (frame_nx == prev) begin
      stb_nx = (stb == STB_MAX) ? stb : stb + SW'(1);
    end
  end

  // locate the lowest set key of the new frame
  always_comb begin
    hit_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (frame_nx[i]) hit_idx = 4'(i);
    end
  end

  assign commit = frame_done
               && (stb_nx == STB_MAX)
               && (frame_nx != deb);

  // exactly one key down, and it is newly down
  assign single_new = (frame_nx != 16'h0)
                   && ((frame_nx & (frame_nx - 16'd1)) == 16'h0)
                   && ((frame_nx & ~deb) != 16'h0);

  // frame capture, debounce and commit
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame     <= '0;
      prev      <= '0;
      deb       <= '0;
      stb       <= '0;
      key_down  <= 1'b0;
      push_pend <= 1'b0;
      push_code <= 4'h0;
    end else begin
      push_pend <= 1'b0;
      if (sample) begin
        frame <= frame_nx;
      end
      if (frame_done) begin
        stb <= stb_nx;
        if (frame_nx != prev) begin
          prev <= frame_nx;
        end
      end
      if (commit) begin
        deb       <= frame_nx;
        key_down  <= |frame_nx;
        push_pend <= single_new;
        push_code <= key_code(hit_idx);
      end
    end
  end

  assign full   = (count == FULL_CNT);
  assign do_pop = ev_pop && (count != '0);
  assign wr_en  = push_pend && (!full || do_pop);
  assign drop   = push_pend && full && !do_pop;

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wp] <= push_code;
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      case ({wr_en, do_pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  assign ev_valid   = (count != '0);
  assign ev_code    = ev_valid ? mem[rp] : 4'h0;
  assign fifo_count = count;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl with a small
// keypad model driving rows from the column drive.
module tb_keypad_scan_ctrl;

  localparam int DEPTH = 4;
  localparam int FRAME = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row;
  logic [3:0] col;
  logic       ev_valid;
  logic [3:0] ev_code;
  logic       ev_pop;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       ovf_clr;
  logic       key_down;

  logic [15:0] keys;
  logic [3:0]  sb[$];
  logic        exp_ovf;
  int          cyc;
  int          n_run;
  int          n_fail;

  // independent code table, index col*4+row
  logic [3:0] kmap [16] = '{
    4'h1, 4'h4, 4'h7, 4'hE,
    4'h2, 4'h5, 4'h8, 4'h0,
    4'h3, 4'h6, 4'h9, 4'hF,
    4'hA, 4'hB, 4'hC, 4'hD
  };

  keypad_scan_ctrl #(
    .SCAN_DIV(4),
    .DEBOUNCE_SCANS(2),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .row(row),
    .col(col),
    .ev_valid(ev_valid),
    .ev_code(ev_code),
    .ev_pop(ev_pop),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .ovf_clr(ovf_clr),
    .key_down(key_down)
  );

  always #5 clk = ~clk;

  // keypad matrix: a pressed key pulls its row low
  always_comb begin
    row = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (col[c] && keys[c*4+r]) row[r] = 1'b0;
      end
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic r;
    r = rst;
    @(posedge clk);
    #1;
    if (!r) cyc = 0;
    else cyc++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic align();
    for (int i = 0; i < FRAME && (cyc % FRAME) != 0; i++)
      tick();
  endtask

  task automatic frames(input int n);
    align();
    ticks(n * FRAME);
  endtask

  // model: a lone new key yields an event or a drop
  task automatic expect_press(input int idx);
    if (sb.size() < DEPTH) sb.push_back(kmap[idx]);
    else exp_ovf = 1'b1;
  endtask

  task automatic press(input int idx, input bit rel);
    align();
    keys = 16'h1 << idx;
    expect_press(idx);
    frames(3);
    if (rel) begin
      keys = 16'h0;
      frames(3);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && ev_valid; i++) begin
      if (sb.size() == 0) begin
        chk("sb_extra_event", sb.size(), 1);
      end else begin
        chk("ev_code_sb", ev_code, sb.pop_front());
      end
      ev_pop = 1'b1;
      tick();
      ev_pop = 1'b0;
    end
    chk("sb_left", sb.size(), 0);
    chk("drained", ev_valid, 0);
  endtask

  initial begin
    logic [3:0] ec;
    n_run   = 0;
    n_fail  = 0;
    cyc     = 0;
    keys    = 16'h0;
    ev_pop  = 1'b0;
    ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    rst     = 1'b0;
    ticks(2);
    rst = 1'b1;

    // 1: reset state and column rotation
    chk("rst_col", col, 4'b0001);
    chk("rst_valid", ev_valid, 0);
    chk("rst_code", ev_code, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_kd", key_down, 0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      ec = 4'b0001 << ((k / 4) % 4);
      chk("col_rot", col, ec);
    end
    frames(2);
    chk("idle_valid", ev_valid, 0);
    chk("idle_kd", key_down, 0);

    // 2: single press of '5'
    align();
    keys = 16'h1 << 5;
    expect_press(5);
    frames(3);
    chk("p5_valid", ev_valid, 1);
    chk("p5_code", ev_code, 4'h5);
    chk("p5_count", fifo_count, 1);
    chk("p5_kd", key_down, 1);
    drain();
    keys = 16'h0;
    frames(3);
    chk("r5_kd", key_down, 0);
    chk("r5_valid", ev_valid, 0);

    // 3: bouncing '9' never commits
    for (int f = 0; f < 6; f++) begin
      align();
      keys = (f % 2 == 0) ? (16'h1 << 10) : 16'h0;
      frames(1);
      chk("b9_kd", key_down, 0);
    end
    keys = 16'h0;
    frames(3);
    chk("b9_valid", ev_valid, 0);

    // 4: two keys then partial release
    align();
    keys = (16'h1 << 0) | (16'h1 << 4);
    frames(3);
    chk("mk_valid", ev_valid, 0);
    chk("mk_kd", key_down, 1);
    keys = 16'h1 << 0;
    frames(3);
    chk("mk_rel_valid", ev_valid, 0);
    chk("mk_rel_kd", key_down, 1);
    keys = 16'h0;
    frames(3);
    chk("mk_up_kd", key_down, 0);
    chk("mk_up_valid", ev_valid, 0);

    // 5: fill, overflow, push with pop while full
    press(0, 1);
    press(4, 1);
    press(8, 1);
    press(12, 1);
    chk("full_ovf_pre", overflow, 0);
    press(3, 1);
    chk("full_count", fifo_count, 4);
    chk("full_head", ev_code, sb[0]);
    chk("full_ovf", overflow, exp_ovf);
    align();
    keys = 16'h1 << 9;
    ticks(32);
    chk("pp_count_pre", fifo_count, 4);
    chk("pp_head_pre", ev_code, sb.pop_front());
    sb.push_back(kmap[9]);
    ev_pop = 1'b1;
    tick();
    ev_pop = 1'b0;
    chk("pp_count", fifo_count, 4);
    chk("pp_head", ev_code, sb[0]);
    chk("pp_head_is_2", ev_code, 4'h2);
    keys = 16'h0;
    frames(3);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    chk("ovf_clr", overflow, exp_ovf);
    drain();

    // 6: mid-scan reset with queued events
    press(2, 1);
    press(6, 1);
    press(10, 0);
    chk("q3_count", fifo_count, 3);
    chk("q3_kd", key_down, 1);
    align();
    ticks(8);
    chk("pre_rst_col", col, 4'b0100);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    sb.delete();
    keys = 16'h0;
    chk("mrst_col", col, 4'b0001);
    chk("mrst_count", fifo_count, 0);
    chk("mrst_valid", ev_valid, 0);
    chk("mrst_ovf", overflow, 0);
    chk("mrst_kd", key_down, 0);

    // operation resumes after reset
    press(7, 1);
    chk("post_count", fifo_count, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
